control_unit_mc: RTL and testbench

Parametrised multi-cycle control unit; successor to the fixed 6-state sequencer. Fetches through a req/ack handshake and latches the instruction register (IR). Decodes opcode, register and offset fields at parametrised widths. Drives PC, register-bank and ALU-select controls, and adds branch, NOP, HALT/resume, fetch timeout and a retired-instruction counter.

---
 rtl/control_unit_mc_if.sv | 40 ++++
 rtl/control_unit_mc.sv | 141 ++++++++++++++
 tb/tb_control_unit_mc.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_mc_if.sv
// Bus bundle between the multi-cycle control unit and its memory/datapath.
// The master modport is the control unit's view of the bus.
interface control_unit_mc_if #(
  parameter int IW    = 16,
  parameter int OPW   = 5,
  parameter int RW    = 4,
  parameter int OFFW  = 10,
  parameter int CNT_W = 16
);
  logic [IW-1:0]    instruction;
  logic             inst_ack;
  logic             zero_flag;
  logic             run;
  logic             inst_req;
  logic             en_pc_2;
  logic             branch_en;
  logic             pc_inc;
  logic [OFFW-1:0]  pc_offset;
  logic [OPW-1:0]   op_code;
  logic [RW-1:0]    src_reg;
  logic [RW-1:0]    dst_reg;
  logic [RW-1:0]    wr_reg;
  logic             wr_en;
  logic [6:0]       fsm_state;
  logic             halted;
  logic             fetch_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  instruction, inst_ack, zero_flag, run,
    output inst_req, en_pc_2, branch_en, pc_inc, pc_offset, op_code, src_reg,
           dst_reg, wr_reg, wr_en, fsm_state, halted, fetch_err, instr_count
  );

  modport slave (
    output instruction, inst_ack, zero_flag, run,
    input  inst_req, en_pc_2, branch_en, pc_inc, pc_offset, op_code, src_reg,
           dst_reg, wr_reg, wr_en, fsm_state, halted, fetch_err, instr_count
  );
endinterface

// File: rtl/control_unit_mc.sv
// Parametrised multi-cycle control unit: fetch/decode/read/exec/write-back
// sequencer with branch, NOP, HALT/resume, fetch timeout and retire counter.
module control_unit_mc #(
  parameter int             IW      = 16,
  parameter int             OPW     = 5,
  parameter int             RW      = 4,
  parameter int             OFFW    = 10,
  parameter logic [OPW-1:0] OP_NOP  = '0,
  parameter logic [OPW-1:0] OP_JMP  = 5'h10,
  parameter logic [OPW-1:0] OP_BZ   = 5'h11,
  parameter logic [OPW-1:0] OP_CMP  = 5'h0E,
  parameter logic [OPW-1:0] OP_HALT = 5'h1F,
  parameter int             TMO_W   = 4,
  parameter int             CNT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  control_unit_mc_if.master  bus
);

  typedef enum logic [6:0] {
    S_FETCH  = 7'b0000001,
    S_INC    = 7'b0000010,
    S_DECODE = 7'b0000100,
    S_READ   = 7'b0001000,
    S_EXEC   = 7'b0010000,
    S_WB     = 7'b0100000,
    S_HALT   = 7'b1000000
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2**TMO_W) - 2);

  state_t           state, state_nxt;
  logic [IW-1:0]    ir;
  logic [TMO_W-1:0] tmo;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic             zf_q;

  logic             ld_ir, tmo_inc, tmo_clr, set_err, clr_err, retire;
  logic [OPW-1:0]   op;
  logic             take_branch;

  assign op          = ir[IW-1 -: OPW];
  assign take_branch = (op == OP_JMP) || ((op == OP_BZ) && zf_q);

  always_comb begin
    state_nxt = state;
    ld_ir     = 1'b0;
    tmo_inc   = 1'b0;
    tmo_clr   = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (bus.inst_ack) begin
          ld_ir     = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = S_INC;
        end else if (tmo == TMO_LAST) begin
          // this wait cycle is the (2**TMO_W-1)-th without an ack
          set_err   = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          tmo_inc   = 1'b1;
        end
      end
      S_INC:    state_nxt = S_DECODE;
      S_DECODE: begin
        if (op == OP_HALT) begin
          retire    = 1'b1;
          state_nxt = S_HALT;
        end else if (op == OP_NOP) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_READ;
        end
      end
      S_READ:   state_nxt = S_EXEC;
      S_EXEC: begin
        if ((op == OP_JMP) || (op == OP_BZ)) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (bus.run) begin
          clr_err   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      ir    <= '0;
      tmo   <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
      zf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_ir)        ir    <= bus.instruction;
      if (tmo_clr)      tmo   <= '0;
      else if (tmo_inc) tmo   <= tmo + 1'b1;
      if (set_err)      err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;
      if (retire)       cnt   <= cnt + 1'b1;
      // zero flag is captured entering EXEC so EXEC strobes stay register-driven
      if (state == S_READ) zf_q <= bus.zero_flag;
    end
  end

  assign bus.inst_req    = (state == S_FETCH);
  assign bus.en_pc_2     = (state == S_INC);
  assign bus.branch_en   = (state == S_EXEC) && take_branch;
  assign bus.pc_inc      = (state == S_INC) || ((state == S_EXEC) && take_branch);
  assign bus.pc_offset   = ir[OFFW-1:0];
  assign bus.op_code     = op;
  assign bus.dst_reg     = ir[IW-OPW-1 -: RW];
  assign bus.src_reg     = ir[IW-OPW-RW-1 -: RW];
  assign bus.wr_reg      = ir[IW-OPW-1 -: RW];
  assign bus.wr_en       = (state == S_WB) && (op != OP_CMP);
  assign bus.fsm_state   = state;
  assign bus.halted      = (state == S_HALT);
  assign bus.fetch_err   = err_q;
  assign bus.instr_count = cnt;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc; a 4-bit retire counter makes the wrap reachable.
module tb_control_unit_mc;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  control_unit_mc_if #(.CNT_W(4)) bus ();

  control_unit_mc #(.CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // hold reset with the given instruction/ack, then release in FETCH
  task automatic start(input logic [15:0] instr, input logic ack, input logic zf);
    rst = 1'b0;
    bus.run = 1'b0;
    bus.instruction = instr;
    bus.inst_ack = ack;
    bus.zero_flag = zf;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    start(16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    cyc();
    checks++;
    if (bus.fsm_state !== 7'b0000001) begin
      errors++; $display("FAIL reset_state: got %b expected 0000001", bus.fsm_state);
    end
    checks++;
    if ({bus.inst_req, bus.en_pc_2, bus.branch_en, bus.pc_inc, bus.wr_en, bus.halted, bus.fetch_err} !== 7'b1000000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 1000000",
        {bus.inst_req, bus.en_pc_2, bus.branch_en, bus.pc_inc, bus.wr_en, bus.halted, bus.fetch_err});
    end
    checks++;
    if ({bus.op_code, bus.pc_offset, bus.instr_count} !== 19'h0) begin
      errors++; $display("FAIL reset_fields: got %h expected 0", {bus.op_code, bus.pc_offset, bus.instr_count});
    end
  endtask

  task automatic test_alu_op();
    logic [6:0] exp_st [6] = '{7'd1, 7'd2, 7'd4, 7'd8, 7'd16, 7'd32};
    start(16'h0A18, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.fsm_state !== exp_st[i]) begin
        errors++; $display("FAIL alu_state[%0d]: got %b expected %b", i, bus.fsm_state, exp_st[i]);
      end
      if (i == 1) begin
        checks++;
        if ({bus.pc_inc, bus.en_pc_2} !== 2'b11) begin
          errors++; $display("FAIL alu_inc: got %b expected 11", {bus.pc_inc, bus.en_pc_2});
        end
      end
      if (i == 3) begin
        checks++;
        if ({bus.op_code, bus.dst_reg, bus.src_reg} !== {5'd1, 4'd4, 4'd3}) begin
          errors++; $display("FAIL alu_fields: got %h expected %h", {bus.op_code, bus.dst_reg, bus.src_reg}, {5'd1, 4'd4, 4'd3});
        end
      end
      if (i == 5) begin
        checks++;
        if ({bus.wr_en, bus.wr_reg} !== 5'b1_0100) begin
          errors++; $display("FAIL alu_wb: got %b expected 10100", {bus.wr_en, bus.wr_reg});
        end
      end
      cyc();
    end
    checks++;
    if ({bus.fsm_state, bus.instr_count} !== {7'd1, 4'd1}) begin
      errors++; $display("FAIL alu_retire: got %h expected %h", {bus.fsm_state, bus.instr_count}, {7'd1, 4'd1});
    end
  endtask

  task automatic test_ack_wait();
    int n = 0;
    int req = 0;
    start(16'h0A18, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_count != 4'd0) break;
      if (i == 3) bus.inst_ack = 1'b1;
      if (bus.inst_req) req++;
      cyc();
      n++;
    end
    checks++;
    if (n !== 9) begin
      errors++; $display("FAIL wait_cycles: got %0d expected 9", n);
    end
    checks++;
    if (req !== 4) begin
      errors++; $display("FAIL wait_req: got %0d expected 4", req);
    end
    checks++;
    if (bus.fetch_err !== 1'b0) begin
      errors++; $display("FAIL wait_err: got %b expected 0", bus.fetch_err);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    start(16'h0A18, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (bus.halted) break;
      cyc();
      n++;
    end
    checks++;
    if (n !== 15) begin
      errors++; $display("FAIL tmo_cycles: got %0d expected 15", n);
    end
    checks++;
    if ({bus.fsm_state, bus.fetch_err, bus.halted, bus.instr_count} !== {7'b1000000, 1'b1, 1'b1, 4'd0}) begin
      errors++; $display("FAIL tmo_halt: got %h expected %h",
        {bus.fsm_state, bus.fetch_err, bus.halted, bus.instr_count}, {7'b1000000, 1'b1, 1'b1, 4'd0});
    end
    cyc();
    cyc();
    checks++;
    if (bus.halted !== 1'b1) begin
      errors++; $display("FAIL tmo_hold: got %b expected 1", bus.halted);
    end
    bus.run = 1'b1;
    cyc();
    bus.run = 1'b0;
    checks++;
    if ({bus.fsm_state, bus.fetch_err, bus.halted} !== {7'b0000001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tmo_resume: got %h expected %h", {bus.fsm_state, bus.fetch_err, bus.halted}, {7'b0000001, 2'b00});
    end
    // ack arriving on the final wait cycle beats the timeout
    start(16'h0A18, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc();
    checks++;
    if (bus.fsm_state !== 7'b0000001) begin
      errors++; $display("FAIL tmo_edge_wait: got %b expected 0000001", bus.fsm_state);
    end
    bus.inst_ack = 1'b1;
    cyc();
    checks++;
    if ({bus.fsm_state, bus.fetch_err} !== {7'b0000010, 1'b0}) begin
      errors++; $display("FAIL tmo_ack_wins: got %h expected %h", {bus.fsm_state, bus.fetch_err}, {7'b0000010, 1'b0});
    end
  endtask

  task automatic test_branch();
    logic [15:0] instr [3] = '{16'h8BF0, 16'h8BF0, 16'h8005};
    logic        zf    [3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0]  exp_s [3] = '{3'b110, 3'b000, 3'b110};
    logic [9:0]  exp_o [3] = '{10'h3F0, 10'h3F0, 10'h005};
    for (int t = 0; t < 3; t++) begin
      start(instr[t], 1'b1, zf[t]);
      for (int i = 0; i < 4; i++) cyc();
      checks++;
      if ({bus.fsm_state, bus.pc_offset} !== {7'b0010000, exp_o[t]}) begin
        errors++; $display("FAIL br_exec[%0d]: got %h expected %h", t, {bus.fsm_state, bus.pc_offset}, {7'b0010000, exp_o[t]});
      end
      checks++;
      if ({bus.branch_en, bus.pc_inc, bus.en_pc_2} !== exp_s[t]) begin
        errors++; $display("FAIL br_strobe[%0d]: got %b expected %b", t, {bus.branch_en, bus.pc_inc, bus.en_pc_2}, exp_s[t]);
      end
      cyc();
      checks++;
      if ({bus.fsm_state, bus.instr_count, bus.branch_en, bus.wr_en} !== {7'b0000001, 4'd1, 2'b00}) begin
        errors++; $display("FAIL br_retire[%0d]: got %h expected %h", t,
          {bus.fsm_state, bus.instr_count, bus.branch_en, bus.wr_en}, {7'b0000001, 4'd1, 2'b00});
      end
    end
  endtask

  task automatic test_cmp_nop_halt();
    start(16'h7100, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if ({bus.fsm_state, bus.wr_en, bus.wr_reg} !== {7'b0100000, 1'b0, 4'd2}) begin
      errors++; $display("FAIL cmp_wb: got %h expected %h", {bus.fsm_state, bus.wr_en, bus.wr_reg}, {7'b0100000, 1'b0, 4'd2});
    end
    cyc();
    checks++;
    if (bus.instr_count !== 4'd1) begin
      errors++; $display("FAIL cmp_retire: got %0d expected 1", bus.instr_count);
    end
    start(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if ({bus.fsm_state, bus.instr_count} !== {7'b0000001, 4'd1}) begin
      errors++; $display("FAIL nop: got %h expected %h", {bus.fsm_state, bus.instr_count}, {7'b0000001, 4'd1});
    end
    start(16'hF800, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    bus.inst_ack = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if ({bus.fsm_state, bus.halted, bus.instr_count, bus.fetch_err, bus.pc_inc, bus.wr_en} !== {7'b1000000, 1'b1, 4'd1, 3'b000}) begin
      errors++; $display("FAIL halt: got %h expected %h",
        {bus.fsm_state, bus.halted, bus.instr_count, bus.fetch_err, bus.pc_inc, bus.wr_en}, {7'b1000000, 1'b1, 4'd1, 3'b000});
    end
    bus.run = 1'b1;
    cyc();
    bus.run = 1'b0;
    checks++;
    if ({bus.fsm_state, bus.halted} !== {7'b0000001, 1'b0}) begin
      errors++; $display("FAIL halt_resume: got %h expected %h", {bus.fsm_state, bus.halted}, {7'b0000001, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    start(16'h8005, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc();
    checks++;
    if (bus.branch_en !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got %b expected 1", bus.branch_en);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if ({bus.fsm_state, bus.branch_en, bus.instr_count} !== {7'b0000001, 1'b0, 4'd0}) begin
      errors++; $display("FAIL mid_reset: got %h expected %h", {bus.fsm_state, bus.branch_en, bus.instr_count}, {7'b0000001, 1'b0, 4'd0});
    end
  endtask

  task automatic test_wrap();
    start(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 45; i++) cyc();
    checks++;
    if (bus.instr_count !== 4'hF) begin
      errors++; $display("FAIL wrap_full: got %0d expected 15", bus.instr_count);
    end
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (bus.instr_count !== 4'h0) begin
      errors++; $display("FAIL wrap_zero: got %0d expected 0", bus.instr_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.instruction = '0;
    bus.inst_ack = 1'b0;
    bus.zero_flag = 1'b0;
    bus.run = 1'b0;
    test_reset();
    test_alu_op();
    test_ack_wait();
    test_timeout();
    test_branch();
    test_cmp_nop_halt();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
